// File: rtl/pig_pkg.sv
// rtl/pig_pkg.sv - shared state encoding and default constants for the Pig game controller
package pig_pkg;

  typedef enum logic [2:0] {
    ARM  = 3'd0,
    ROLL = 3'd1,
    EVAL = 3'd2,
    BANK = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int SCORE_W_DEF   = 7;
  localparam int WIN_SCORE_DEF = 100;
  localparam int DIE_MAX       = 6;

endpackage

// File: rtl/pig_game_rise_detect.sv
// rtl/pig_game_rise_detect.sv - single-bit rising-edge detector with configurable history reset value
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // History follows the input every cycle
  always_comb begin
    prev_d = d;
  end

  // History register; a reset value of 1 suppresses an edge for a level already high at reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= RESET_VAL;
    else        prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/pig_game.sv
// rtl/pig_game.sv - two-player Pig controller: turn accumulation, banking, player alternation, winner
module pig_game
  import pig_pkg::*;
#(
  parameter int WIN_SCORE = WIN_SCORE_DEF,
  parameter int SCORE_W   = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         num,
  input  logic               choose,
  input  logic               hold_btn,
  input  logic               new_game,
  output logic               roll_enable,
  output logic               player,
  output logic [SCORE_W-1:0] turn_total,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [2:0]         last_die,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic               player_q, player_d;
  logic [SCORE_W-1:0] tt_q, tt_d;
  logic [SCORE_W-1:0] s0_q, s0_d;
  logic [SCORE_W-1:0] s1_q, s1_d;
  logic [2:0]         last_q, last_d;
  logic               go_q, go_d;
  logic               win_q, win_d;
  logic               re_q, re_d;

  logic               hold_rise;
  logic               num_legal;
  logic [SCORE_W-1:0] active;
  logic [SCORE_W-1:0] new_tt;
  logic [SCORE_W-1:0] new_score;

  // History reset to 1 so a button held through reset does not count as a press
  rise_detect #(.RESET_VAL(1'b1)) u_hold_rise (
    .clk   (clk),
    .rst_n (rst),
    .d     (hold_btn),
    .rise  (hold_rise)
  );

  assign num_legal = (num != 3'd0) && (num <= 3'(DIE_MAX));
  assign active    = player_q ? s1_q : s0_q;
  assign new_tt    = tt_q + SCORE_W'(last_q);
  assign new_score = active + tt_q;

  // Next-state and datapath decisions; new_game overrides every transition
  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    tt_d     = tt_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    last_d   = last_q;
    go_d     = go_q;
    win_d    = win_q;
    case (state_q)
      ARM: state_d = ROLL;
      ROLL: begin
        if (choose && num_legal) begin
          last_d  = num;
          state_d = EVAL;
        end else if (hold_rise && (tt_q != '0)) begin
          state_d = BANK;
        end
      end
      EVAL: begin
        if (last_q == 3'd1) begin
          tt_d     = '0;
          player_d = ~player_q;
          state_d  = ARM;
        end else begin
          tt_d    = new_tt;
          state_d = ((active + new_tt) >= WIN_V) ? BANK : ARM;
        end
      end
      BANK: begin
        if (player_q) s1_d = new_score;
        else          s0_d = new_score;
        tt_d = '0;
        if (new_score >= WIN_V) begin
          go_d    = 1'b1;
          win_d   = player_q;
          state_d = DONE;
        end else begin
          player_d = ~player_q;
          state_d  = ARM;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = ARM;
    endcase
    if (new_game) begin
      state_d  = ARM;
      player_d = 1'b0;
      tt_d     = '0;
      s0_d     = '0;
      s1_d     = '0;
      last_d   = 3'd0;
      go_d     = 1'b0;
      win_d    = 1'b0;
    end
    re_d = (state_d == ROLL);
  end

  // All state and outputs registered together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARM;
      player_q <= 1'b0;
      tt_q     <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      last_q   <= 3'd0;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      tt_q     <= tt_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      last_q   <= last_d;
      go_q     <= go_d;
      win_q    <= win_d;
      re_q     <= re_d;
    end
  end

  assign roll_enable = re_q;
  assign player      = player_q;
  assign turn_total  = tt_q;
  assign score0      = s0_q;
  assign score1      = s1_q;
  assign last_die    = last_q;
  assign game_over   = go_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_pig_game.sv
// tb/tb_pig_game.sv - scoreboard bench for pig_game
module tb_pig_game;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] num = 3'd0;
  logic       choose = 1'b0;
  logic       hold_btn = 1'b0;
  logic       new_game = 1'b0;
  logic       roll_enable;
  logic       player;
  logic [6:0] turn_total;
  logic [6:0] score0;
  logic [6:0] score1;
  logic [2:0] last_die;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int failures = 0;
  logic [26:0] exp_q[$];

  pig_game #(.WIN_SCORE(100), .SCORE_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .num         (num),
    .choose      (choose),
    .hold_btn    (hold_btn),
    .new_game    (new_game),
    .roll_enable (roll_enable),
    .player      (player),
    .turn_total  (turn_total),
    .score0      (score0),
    .score1      (score1),
    .last_die    (last_die),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] mk(input logic p, input int tt, input int s0, input int s1,
                                     input int ld, input logic go, input logic w);
    return {p, 7'(tt), 7'(s0), 7'(s1), 3'(ld), go, w};
  endfunction

  function automatic logic [26:0] snap();
    return {player, turn_total, score0, score1, last_die, game_over, winner};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_roll();
    int n = 0;
    while (roll_enable !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (roll_enable !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_roll timeout actual=%b required=1", roll_enable);
    end
  endtask

  task automatic roll(input int v);
    wait_roll();
    num = 3'(v);
    choose = 1'b1;
    @(negedge clk);
    choose = 1'b0;
    num = 3'd0;
  endtask

  task automatic do_hold();
    wait_roll();
    hold_btn = 1'b1;
    @(negedge clk);
    hold_btn = 1'b0;
  endtask

  // Monitor: snapshot compared at every roll_enable rise and game_over rise
  initial begin
    logic prev_re = 1'b0;
    logic prev_go = 1'b0;
    logic [26:0] e;
    forever begin
      @(negedge clk);
      if (rst && ((roll_enable && !prev_re) || (game_over && !prev_go))) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected actual=%h required=none", snap());
        end else begin
          e = exp_q.pop_front();
          if (snap() !== e) begin
            failures++;
            $display("FAIL sb_snapshot actual=%h required=%h", snap(), e);
          end
        end
      end
      prev_re = roll_enable;
      prev_go = game_over;
    end
  end

  initial begin
    // Reset and first ROLL
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("first_cycle_re", 32'(roll_enable), 32'd0);
    chk("reset_scores", {player, score0, score1, turn_total}, 32'd0);

    // Player 0: 4, 5, hold
    exp_q.push_back(mk(0, 4, 0, 0, 4, 0, 0));
    roll(4);
    exp_q.push_back(mk(0, 9, 0, 0, 5, 0, 0));
    roll(5);
    exp_q.push_back(mk(1, 0, 9, 0, 5, 0, 0));
    do_hold();

    // Player 1: 3, then 1 forfeits
    exp_q.push_back(mk(1, 3, 9, 0, 3, 0, 0));
    roll(3);
    exp_q.push_back(mk(0, 0, 9, 0, 1, 0, 0));
    roll(1);

    // choose and hold edge together: choose wins, held level never banks
    exp_q.push_back(mk(0, 2, 9, 0, 2, 0, 0));
    wait_roll();
    num = 3'd2;
    choose = 1'b1;
    hold_btn = 1'b1;
    @(negedge clk);
    choose = 1'b0;
    num = 3'd0;
    wait_roll();
    repeat (5) @(negedge clk);
    chk("held_no_bank", {roll_enable, score0, turn_total}, {1'b1, 7'd9, 7'd2});
    hold_btn = 1'b0;
    @(negedge clk);

    // Player 0 builds to 95 and banks
    for (int k = 1; k <= 14; k++) begin
      exp_q.push_back(mk(0, 2 + 6 * k, 9, 0, 6, 0, 0));
      roll(6);
    end
    exp_q.push_back(mk(1, 0, 95, 0, 6, 0, 0));
    do_hold();
    exp_q.push_back(mk(0, 0, 95, 0, 1, 0, 0));
    roll(1);

    // Automatic win bank: 95 + 6 = 101
    exp_q.push_back(mk(0, 0, 101, 0, 6, 1, 0));
    roll(6);
    repeat (4) @(negedge clk);
    num = 3'd5;
    choose = 1'b1;
    repeat (3) @(negedge clk);
    choose = 1'b0;
    num = 3'd0;
    chk("done_frozen", {roll_enable, game_over, winner, last_die, score0},
        {1'b0, 1'b1, 1'b0, 3'd6, 7'd101});

    // new_game from DONE, then player 1 reaches 40
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0));
    roll(1);
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(mk(1, 6 * k, 0, 0, 6, 0, 0));
      roll(6);
    end
    exp_q.push_back(mk(1, 40, 0, 0, 4, 0, 0));
    roll(4);
    exp_q.push_back(mk(0, 0, 0, 40, 4, 0, 0));
    do_hold();
    exp_q.push_back(mk(0, 2, 0, 40, 2, 0, 0));
    roll(2);

    // new_game mid-ROLL
    wait_roll();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("new_game_clear", {roll_enable, snap()}, 32'd0);

    // Reset with hold held, then illegal die values
    wait_roll();
    rst = 1'b0;
    hold_btn = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(mk(0, 3, 0, 0, 3, 0, 0));
    roll(3);
    wait_roll();
    repeat (5) @(negedge clk);
    chk("reset_held_no_bank", {player, score0, turn_total}, {1'b0, 7'd0, 7'd3});
    num = 3'd0;
    choose = 1'b1;
    repeat (2) @(negedge clk);
    num = 3'd7;
    repeat (2) @(negedge clk);
    choose = 1'b0;
    num = 3'd0;
    chk("illegal_num", {roll_enable, last_die, turn_total}, {1'b1, 3'd3, 7'd3});
    hold_btn = 1'b0;
    @(negedge clk);
    exp_q.push_back(mk(1, 0, 3, 0, 3, 0, 0));
    do_hold();

    repeat (10) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
